// File: rtl/sgmii_pkg.sv
// Shared definitions for SGMII auto-negotiation: state encodings, config-word
// bit positions and partner speed codes.
package sgmii_pkg;

   typedef enum logic [2:0] {
      AN_DISABLE  = 3'd0,
      AN_ABILITY  = 3'd1,
      AN_ACK      = 3'd2,
      AN_COMPLETE = 3'd3,
      AN_IDLE_DET = 3'd4,
      AN_LINK_OK  = 3'd5
   } an_state_e;

   localparam int CFG_ACK_BIT    = 14;
   localparam int CFG_DUPLEX_BIT = 12;
   localparam int CFG_SPEED_HI   = 11;
   localparam int CFG_SPEED_LO   = 10;
   localparam int CFG_SGMII_BIT  = 0;

   localparam logic [1:0] SPEED_10M  = 2'b00;
   localparam logic [1:0] SPEED_100M = 2'b01;
   localparam logic [1:0] SPEED_1G   = 2'b10;
   localparam logic [1:0] SPEED_RSVD = 2'b11;

   localparam int AN_TIMER_W = 18;

   // The reserved speed code is treated as 1G.
   function automatic logic [1:0] decode_speed(input logic [1:0] code);
      return (code == SPEED_RSVD) ? SPEED_1G : code;
   endfunction

endpackage

// File: rtl/sgmii_an_timer.sv
// Link timer: loadable down-counter that holds at zero and flags expiry.
module sgmii_an_timer
   import sgmii_pkg::*;
#(
   parameter int LINK_TIMER = 200000
) (
   input  logic clk_125mhz,
   input  logic rst,
   input  logic load,
   output logic expired
);

   localparam logic [AN_TIMER_W-1:0] LOAD_VAL = AN_TIMER_W'(LINK_TIMER - 1);

   logic [AN_TIMER_W-1:0] cnt_q, cnt_d;

   // Load takes priority; otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - AN_TIMER_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_125mhz) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/sgmii_autoneg_ctrl.sv
// SGMII auto-negotiation sequencer for one port.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   DISABLE   | no code-group sync, nothing sent
//   ABILITY   | sending config words, waiting for partner ability
//   ACK       | ability latched, acking, waiting for partner ack
//   COMPLETE  | both acked, running the link timer
//   IDLE_DET  | sending idles, waiting for partner idles + timer
//   LINK_OK   | link up, speed/duplex valid
module sgmii_autoneg_ctrl
   import sgmii_pkg::*;
#(
   parameter int LINK_TIMER = 200000,
   parameter int MATCH_CNT  = 3
) (
   input  logic        clk_125mhz,
   input  logic        rst,
   input  logic        rx_sync,
   input  logic        rx_cfg_valid,
   input  logic [15:0] rx_cfg_word,
   input  logic        rx_idle_valid,
   input  logic        an_restart,
   output logic        sgmii_autoneg_start,
   output logic        sgmii_autoneg_ack,
   output logic        sgmii_autoneg_done,
   output logic        link_up,
   output logic [1:0]  link_speed,
   output logic        link_duplex,
   output logic [2:0]  an_state
);

   localparam logic [2:0]  MATCH_N   = 3'(MATCH_CNT);
   // The partner's ack bit toggles between ABILITY and ACK, so it is not part of the ability compare.
   localparam logic [15:0] ABIL_MASK = ~(16'd1 << CFG_ACK_BIT);

   an_state_e   state_q, state_d;
   logic [15:0] prev_q, prev_d;
   logic [2:0]  cnt_q, cnt_d, cnt_nxt;
   logic [13:0] ability_q, ability_d;
   logic [1:0]  speed_q, speed_d;
   logic        duplex_q, duplex_d;
   logic        start_q, start_d, ack_q, ack_d, done_q, done_d, link_up_q, link_up_d;
   logic        cfg_ok, cfg_same, match_hit, idle_hit;
   logic        timer_load, timer_expired;

   sgmii_an_timer #(.LINK_TIMER(LINK_TIMER)) u_timer (
      .clk_125mhz (clk_125mhz),
      .rst        (rst),
      .load       (timer_load),
      .expired    (timer_expired)
   );

   // Consecutive-match counter for config words (or idles in IDLE_DET).
   always_comb begin
      cfg_ok   = 1'b1;
      cfg_same = (rx_cfg_word == prev_q);
      case (state_q)
         AN_ABILITY: begin
            cfg_ok   = rx_cfg_word[CFG_SGMII_BIT];
            cfg_same = ((rx_cfg_word ^ prev_q) & ABIL_MASK) == '0;
         end
         AN_ACK: cfg_ok = rx_cfg_word[CFG_ACK_BIT] && (rx_cfg_word[13:0] == ability_q);
         default: ;
      endcase
      prev_d  = prev_q;
      cnt_nxt = cnt_q;
      if (rx_cfg_valid) begin
         prev_d = rx_cfg_word;
         if (rx_cfg_word == '0 || !cfg_ok || state_q == AN_IDLE_DET) begin
            cnt_nxt = 3'd0;
         end else if (!cfg_same) begin
            cnt_nxt = 3'd1;
         end else if (cnt_q != MATCH_N) begin
            cnt_nxt = cnt_q + 3'd1;
         end
      end else if (rx_idle_valid && state_q == AN_IDLE_DET && cnt_q != MATCH_N) begin
         cnt_nxt = cnt_q + 3'd1;
      end
      match_hit = rx_cfg_valid && (cnt_nxt == MATCH_N);
      idle_hit  = (cnt_nxt == MATCH_N);
   end

   // Next state, overrides, latches and registered output values.
   always_comb begin
      state_d = state_q;
      case (state_q)
         AN_DISABLE:  if (rx_sync) state_d = AN_ABILITY;
         AN_ABILITY:  if (match_hit) state_d = AN_ACK;
         AN_ACK: begin
            if (rx_cfg_valid && rx_cfg_word[13:0] != ability_q) state_d = AN_ABILITY;
            else if (match_hit) state_d = AN_COMPLETE;
         end
         AN_COMPLETE: if (timer_expired) state_d = AN_IDLE_DET;
         AN_IDLE_DET: begin
            if (rx_cfg_valid && rx_cfg_word == '0) state_d = AN_ABILITY;
            else if (idle_hit && timer_expired) state_d = AN_LINK_OK;
         end
         AN_LINK_OK:  if (rx_cfg_valid) state_d = AN_ABILITY;
         default:     state_d = AN_DISABLE;
      endcase
      if (rx_cfg_valid && rx_cfg_word == '0 && (state_q == AN_ACK || state_q == AN_COMPLETE))
         state_d = AN_ABILITY;
      if (an_restart && state_q != AN_DISABLE) state_d = AN_ABILITY;
      if (!rx_sync) state_d = AN_DISABLE;

      cnt_d      = (state_d != state_q || an_restart) ? 3'd0 : cnt_nxt;
      timer_load = (state_d != state_q) && (state_d == AN_COMPLETE || state_d == AN_IDLE_DET);

      ability_d = ability_q;
      speed_d   = speed_q;
      duplex_d  = duplex_q;
      if (state_q == AN_ABILITY && state_d == AN_ACK) begin
         ability_d = rx_cfg_word[13:0];
         speed_d   = decode_speed(rx_cfg_word[CFG_SPEED_HI:CFG_SPEED_LO]);
         duplex_d  = rx_cfg_word[CFG_DUPLEX_BIT];
      end

      start_d   = (state_d != AN_DISABLE);
      ack_d     = (state_d == AN_ACK) || (state_d == AN_COMPLETE);
      done_d    = (state_d == AN_IDLE_DET) || (state_d == AN_LINK_OK);
      link_up_d = (state_d == AN_LINK_OK);
   end

   // State, match and output registers.
   always_ff @(posedge clk_125mhz) begin
      if (rst) begin
         state_q   <= AN_DISABLE;
         prev_q    <= '0;
         cnt_q     <= '0;
         ability_q <= '0;
         speed_q   <= SPEED_1G;
         duplex_q  <= 1'b0;
         start_q   <= 1'b0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         link_up_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         ability_q <= ability_d;
         speed_q   <= speed_d;
         duplex_q  <= duplex_d;
         start_q   <= start_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         link_up_q <= link_up_d;
      end
   end

   assign sgmii_autoneg_start = start_q;
   assign sgmii_autoneg_ack   = ack_q;
   assign sgmii_autoneg_done  = done_q;
   assign link_up             = link_up_q;
   assign link_speed          = speed_q;
   assign link_duplex         = duplex_q;
   assign an_state            = state_q;

endmodule

// File: tb/tb_sgmii_autoneg_ctrl.sv
// Directed bench for sgmii_autoneg_ctrl with a cycle-tagged scoreboard.
module tb_sgmii_autoneg_ctrl;

   localparam int LT = 16;
   localparam int MC = 3;

   logic        clk = 1'b0;
   logic        rst, rx_sync, rx_cfg_valid, rx_idle_valid, an_restart;
   logic [15:0] rx_cfg_word;
   logic        start, ack, done, link_up, link_duplex;
   logic [1:0]  link_speed;
   logic [2:0]  an_state;

   always #4 clk = ~clk;

   sgmii_autoneg_ctrl #(.LINK_TIMER(LT), .MATCH_CNT(MC)) dut (
      .clk_125mhz          (clk),
      .rst                 (rst),
      .rx_sync             (rx_sync),
      .rx_cfg_valid        (rx_cfg_valid),
      .rx_cfg_word         (rx_cfg_word),
      .rx_idle_valid       (rx_idle_valid),
      .an_restart          (an_restart),
      .sgmii_autoneg_start (start),
      .sgmii_autoneg_ack   (ack),
      .sgmii_autoneg_done  (done),
      .link_up             (link_up),
      .link_speed          (link_speed),
      .link_duplex         (link_duplex),
      .an_state            (an_state)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] st;
      logic [3:0] ctl;
      logic       chk_link;
      logic [1:0] spd;
      logic       dup;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // {start, ack, done, link_up} per state, from the output table.
   function automatic logic [3:0] ctl_of(input logic [2:0] st);
      case (st)
         3'd1:    return 4'b1000;
         3'd2:    return 4'b1100;
         3'd3:    return 4'b1100;
         3'd4:    return 4'b1010;
         3'd5:    return 4'b1011;
         default: return 4'b0000;
      endcase
   endfunction

   task automatic push_exp(input string nm, input logic [2:0] st, input logic chk,
                           input logic [1:0] spd, input logic dup);
      exp_t e;
      e.cyc = cyc; e.name = nm; e.st = st; e.ctl = ctl_of(st);
      e.chk_link = chk; e.spd = spd; e.dup = dup;
      sb.push_back(e);
   endtask

   task automatic expect_st(input string nm, input logic [2:0] st);
      push_exp(nm, st, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic expect_link(input string nm, input logic [2:0] st, input logic [1:0] spd, input logic dup);
      push_exp(nm, st, 1'b1, spd, dup);
   endtask

   // Monitor: compare every entry due in the current cycle, away from the clock edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc || an_state != e.st || {start, ack, done, link_up} != e.ctl ||
             (e.chk_link && (link_speed != e.spd || link_duplex != e.dup))) begin
            errors++;
            $display("FAIL %s @cyc %0d: got state=%0d ctl=%b spd=%b dup=%b, expected state=%0d ctl=%b spd=%b dup=%b (due cyc %0d)",
                     e.name, cyc, an_state, {start, ack, done, link_up}, link_speed, link_duplex,
                     e.st, e.ctl, e.spd, e.dup, e.cyc);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_cfg(input logic [15:0] w);
      rx_cfg_valid = 1'b1;
      rx_cfg_word  = w;
      tick();
      rx_cfg_valid = 1'b0;
      rx_cfg_word  = 16'h0000;
   endtask

   task automatic send_idle();
      rx_idle_valid = 1'b1;
      tick();
      rx_idle_valid = 1'b0;
   endtask

   task automatic run_to_link_ok(input logic [15:0] abil, input logic [15:0] ackw,
                                 input logic [1:0] spd, input logic dup);
      send_cfg(abil); expect_st("abil_1", 3'd1);
      send_cfg(abil); expect_st("abil_2", 3'd1);
      send_cfg(abil); expect_st("ack_entry", 3'd2);
      send_cfg(ackw);
      send_cfg(ackw); expect_st("ack_hold", 3'd2);
      send_cfg(ackw); expect_st("complete_entry", 3'd3);
      tick(LT - 1);   expect_st("complete_last", 3'd3);
      tick();         expect_st("idle_det_entry", 3'd4);
      repeat (MC) send_idle();
      tick(LT - 1 - MC); expect_st("idle_det_last", 3'd4);
      tick();         expect_link("link_ok", 3'd5, spd, dup);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rx_sync = 1'b0; rx_cfg_valid = 1'b0; rx_cfg_word = 16'h0;
      rx_idle_valid = 1'b0; an_restart = 1'b0;
      tick(3);
      rst = 1'b0;
      expect_link("reset", 3'd0, 2'b10, 1'b0);
      tick();
      expect_st("disable_no_sync", 3'd0);

      rx_sync = 1'b1;
      tick();
      expect_st("start_after_sync", 3'd1);
      run_to_link_ok(16'h1401, 16'h5401, 2'b01, 1'b1);

      rx_sync = 1'b0;
      tick();
      expect_link("sync_loss", 3'd0, 2'b01, 1'b1);
      rx_sync = 1'b1;
      tick();
      expect_st("resync", 3'd1);
      run_to_link_ok(16'hDC01, 16'hDC01, 2'b10, 1'b1);

      an_restart = 1'b1; rx_idle_valid = 1'b1;
      tick();
      an_restart = 1'b0; rx_idle_valid = 1'b0;
      expect_st("restart_with_idle", 3'd1);

      for (int i = 0; i < 6; i++) begin
         send_cfg((i % 2 == 1) ? 16'h1801 : 16'h1401);
         expect_st("alternating", 3'd1);
      end

      repeat (MC) send_cfg(16'h1401);
      expect_st("ack_before_zero", 3'd2);
      send_cfg(16'h0000);
      expect_st("ack_zero_word", 3'd1);

      repeat (MC) send_cfg(16'h1401);
      expect_st("ack_before_diff", 3'd2);
      send_cfg(16'h1801);
      expect_st("ack_diff_word", 3'd1);

      repeat (MC - 1) send_cfg(16'h1401);
      an_restart = 1'b1;
      send_cfg(16'h1401);
      an_restart = 1'b0;
      expect_st("restart_vs_match", 3'd1);

      repeat (MC) send_cfg(16'h1401);
      expect_st("ack_again", 3'd2);
      repeat (MC) send_cfg(16'h5401);
      tick(LT);
      expect_st("idle_det_again", 3'd4);
      send_cfg(16'h0000);
      expect_st("idle_det_zero_word", 3'd1);

      tick(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sgmii_autoneg_ctrl.md
# sgmii_autoneg_ctrl

Sequences SGMII auto-negotiation for one port. It watches configuration ordered-set words and idles decoded by the TBI receive path, and drives the `sgmii_autoneg_start` / `sgmii_autoneg_ack` / `sgmii_autoneg_done` controls of the SGMII transmit buffer. On completion it latches the partner's link, speed and duplex for the MAC. The block sits between the SGMII RX decoder and `sgmii_tx_buf` in the enet port wrapper.

## Interface
- `LINK_TIMER`, 200000: link-timer length in clocks (1.6 ms at 125 MHz). Benches override to a small value.
- `MATCH_CNT`, 3: number of consecutive identical config words, or idles, required for a match. Legal range 2-7.
- `clk_125mhz`  in  1  single block clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_sync`  in  1  RX decoder has code-group sync.
- `rx_cfg_valid`  in  1  one-cycle strobe: a complete config word was received.
- `rx_cfg_word`  in  16  received config word; valid with `rx_cfg_valid`.
- `rx_idle_valid`  in  1  one-cycle strobe: an /I/ ordered set was received.
- `an_restart`  in  1  one-cycle software restart request.
- `sgmii_autoneg_start`  out  1  to tx_buf: start sending config words.
- `sgmii_autoneg_ack`  out  1  to tx_buf: set the ack bit in sent config words.
- `sgmii_autoneg_done`  out  1  to tx_buf: negotiation finished, send idles/data.
- `link_up`  out  1  link OK.
- `link_speed`  out  2  partner speed: 00 = 10M, 01 = 100M, 10 = 1G.
- `link_duplex`  out  1  1 = full duplex.
- `an_state`  out  3  current state encoding, for debug.

## Operation
- States: DISABLE(0), ABILITY(1), ACK(2), COMPLETE(3), IDLE_DET(4), LINK_OK(5).
- Outputs per state:
  - start = 1 in ABILITY through LINK_OK.
  - ack = 1 in ACK and COMPLETE.
  - done = 1 in IDLE_DET and LINK_OK.
  - link_up = 1 in LINK_OK only.
- `match_cnt` counts consecutive `rx_cfg_valid` words equal to the stored previous word. A differing word reloads the stored word and sets the count to 1. The counter saturates at MATCH_CNT.
- The match counter clears on every state change.
- Transitions:
  - DISABLE -> ABILITY when `rx_sync` = 1.
  - ABILITY -> ACK on ability match: MATCH_CNT identical words with bit0 = 1, ignoring bit14 in the compare. On this transition the block latches `link_speed` = word[11:10], `link_duplex` = word[12], and the ability word itself.
  - ACK -> COMPLETE on MATCH_CNT identical words that have bit14 = 1 and bits[13:0] equal to the latched ability.
  - ACK -> ABILITY on a word whose bits[13:0] differ from the latched ability.
  - COMPLETE -> IDLE_DET when the link timer expires.
  - IDLE_DET -> LINK_OK when MATCH_CNT consecutive `rx_idle_valid` strobes have arrived and the link timer has expired again. The timer restarts on entry to IDLE_DET.
  - IDLE_DET -> ABILITY on any `rx_cfg_valid` with word = 0.
  - LINK_OK -> ABILITY on any `rx_cfg_valid`, because the partner is restarting.
- Global overrides, in priority order:
  1. `rst`: go to DISABLE.
  2. `rx_sync` = 0: go to DISABLE from any state.
  3. `an_restart`: go to ABILITY from any state other than DISABLE.
  4. Received word = 0 in ABILITY, ACK or COMPLETE: reset the match count. Only in ACK or COMPLETE does it also move to ABILITY.
- Link timer: an 18-bit down-counter loaded with LINK_TIMER-1 on entry to COMPLETE and on entry to IDLE_DET. It expires when it reaches 0 and holds at 0.
- A word equal to 0 never counts toward a match.
- `link_speed` value 11 from the partner is reserved. It is latched as 10 (1G).

## Timing
- All outputs are registered and change one cycle after the qualifying input edge.
- Reset values:
  - all control outputs 0;
  - `link_speed` = 10;
  - `link_duplex` = 0;
  - `an_state` = 0.
- Strobe to state change:
  - The MATCH_CNT-th matching strobe in cycle N gives the new state and outputs in cycle N+1.
  - Timer expiry observed in cycle N gives the new state in cycle N+1.
  - COMPLETE therefore lasts exactly LINK_TIMER cycles.
- Simultaneous events:
  - `rx_cfg_valid` and `rx_idle_valid` in the same cycle: the config strobe wins and the idle strobe is ignored.
  - `an_restart` in the same cycle as a match: restart wins.
- `rx_sync` loss mid-operation: in the next cycle done, ack and start are all 0 together, and `link_up` drops in that same cycle.
- Minimum time to LINK_OK from `rx_sync` rising is 1 + 2·MATCH_CNT strobes + 2·LINK_TIMER cycles.

## Structure
- Shared package `sgmii_pkg`:
  - state encodings;
  - config-word bit positions (ACK = 14, DUPLEX = 12, SPEED = 11:10, SGMII = 0);
  - speed codes.
- One sub-module, `sgmii_an_timer`: a loadable down-counter with an `expired` flag.
- The FSM and the match logic stay in the top module.

## Test plan
- LINK_TIMER = 16, MATCH_CNT = 3; rx_sync = 1; three words 0x1401, then three words 0x5401. Required:
  - start rises 1 cycle after sync;
  - ack rises after the 3rd 0x1401;
  - done rises 16 cycles after the 3rd 0x5401;
  - after 3 idles and a further 16 cycles, link_up = 1, link_speed = 01, link_duplex = 1.
- Alternating words 0x1401 and 0x1801 -> the block never leaves ABILITY; ack stays 0.
- In ACK, receive 0x0000 -> next cycle an_state = ABILITY, ack = 0.
- In LINK_OK, drop rx_sync for 1 cycle -> next cycle an_state = DISABLE with start, ack, done and link_up all 0. With rx_sync high again, the full sequence recovers to LINK_OK.
- In LINK_OK, pulse an_restart in the same cycle as rx_idle_valid -> ABILITY with done = 0 and link_up = 0.
- Partner word 0xDC01 -> link_speed latched as 10, link_duplex = 1.
